xalu: RTL and testbench

- Multiply/divide unit in the E stage of the P7 five-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- Its `busy` output is the XALU busy signal read by the D-stage hazard/stall logic. That logic stalls any HI/LO-family instruction in D while `busy` is high, or while an md start is in E.
- The M-stage exception/interrupt request cancels an E-stage issue.

---
 rtl/xalu_if.sv | 14 +
 rtl/xalu.sv | 132 +++++++++++++
 tb/tb_xalu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/xalu_if.sv
// E-stage multiply/divide bus: issue request and operands in, busy flag and HI/LO out.
interface xalu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, req, input busy, HI, LO);
  modport slave  (input start, op, A, B, req, output busy, HI, LO);
endinterface

// File: rtl/xalu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// state | meaning
// IDLE  | no op in flight; accepts mult/div/mthi/mtlo issue
// RUN   | result computed into temp regs; counting down, committed on 1->0
module xalu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  xalu_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] temp_hi_q, temp_hi_d;
  logic [31:0] temp_lo_q, temp_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        issue;
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_safe, uq, ur;
  logic [31:0] a_mag, b_mag, b_mag_safe, sq_mag, sr_mag, sq, sr;

  assign issue = bus.start & ~bus.req & (bus.op != 3'd0) & (bus.op != 3'd7)
               & (state_q == IDLE);

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign b_safe     = (bus.B == 32'd0) ? 32'd1 : bus.B;
  assign uq         = bus.A / b_safe;
  assign ur         = bus.A % b_safe;
  assign a_mag      = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
  assign b_mag      = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign sq_mag     = a_mag / b_mag_safe;
  assign sr_mag     = a_mag % b_mag_safe;
  assign sq         = (bus.A[31] ^ bus.B[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr         = bus.A[31] ? (~sr_mag + 32'd1) : sr_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          case (bus.op)
            OP_MULT: begin
              {temp_hi_d, temp_lo_d} = prod_s;
              cnt_d   = MULT_CNT;
              state_d = RUN;
            end
            OP_MULTU: begin
              {temp_hi_d, temp_lo_d} = prod_u;
              cnt_d   = MULT_CNT;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero still runs the full sequence but recommits the old HI/LO.
              if (bus.B == 32'd0) begin
                temp_hi_d = hi_q;
                temp_lo_d = lo_q;
              end else if (bus.op == OP_DIV) begin
                temp_hi_d = sr;
                temp_lo_d = sq;
              end else begin
                temp_hi_d = ur;
                temp_lo_d = uq;
              end
              cnt_d   = DIV_CNT;
              state_d = RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = temp_hi_q;
          lo_d    = temp_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_xalu.sv
// Directed bench for xalu: hand-computed HI/LO results, busy lengths and boundary cases.
module tb_xalu;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n;

  xalu_if bus ();

  xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents one issue cycle, returns at the following negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.req   = rq;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.req   = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; stops at the first negedge with busy low.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic md_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_len,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0, lo0;
    int cnt;
    hi0 = bus.HI;
    lo0 = bus.LO;
    issue(op, a, b, 1'b0);
    chk({tag, "_hold"}, {bus.HI, bus.LO}, {hi0, lo0});
    count_busy(cnt);
    chk({tag, "_len"}, 64'(cnt), 64'(exp_len));
    chk({tag, "_hi"}, 64'(bus.HI), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.LO), 64'(exp_lo));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.req   = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    md_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    md_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    md_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_op("divu",  3'd4, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
    md_op("div_pn", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    md_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

    issue(3'd5, 32'h1234, 32'd0, 1'b0);
    chk("mthi_hi", 64'(bus.HI), 64'h1234);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    issue(3'd6, 32'h5678, 32'd0, 1'b0);
    chk("mtlo_lo", 64'(bus.LO), 64'h5678);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    md_op("divu0", 3'd4, 32'd9, 32'd0, 10, 32'h1234, 32'h5678);

    issue(3'd7, 32'h1, 32'h1, 1'b0);
    chk("op7_noop", {31'd0, bus.busy, bus.HI, bus.LO}, {32'd0, 32'h1234, 32'h5678});
    issue(3'd1, 32'd5, 32'd7, 1'b1);
    chk("req_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("req_hilo", {bus.HI, bus.LO}, {32'h1234, 32'h5678});

    issue(3'd1, 32'd5, 32'd7, 1'b0);
    chk("rb_busy1", 64'(bus.busy), 64'd1);
    issue(3'd1, 32'd1, 32'd1, 1'b0);
    bus.req = 1'b1;
    count_busy(n);
    bus.req = 1'b0;
    chk("rb_len", 64'(n + 1), 64'd5);
    chk("rb_result", {bus.HI, bus.LO}, {32'd0, 32'd35});

    issue(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_mid_busy_pre", 64'(bus.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_hilo", {bus.HI, bus.LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle", {31'd0, bus.busy, bus.HI, bus.LO}, 64'd0);
    issue(3'd6, 32'd7, 32'd0, 1'b0);
    chk("post_rst_lo", 64'(bus.LO), 64'd7);
    chk("post_rst_hi", 64'(bus.HI), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
